// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: datapath widths, forward-source
// encoding and the buffered instruction entry layout.
package alu_issue_stage_pkg;

  localparam int unsigned RvWordWidth    = 32;
  localparam int unsigned RvAluCtlWidth  = 4;
  localparam int unsigned RvRegAddrWidth = 5;

  typedef enum logic [1:0] {
    FwdNone = 2'd0,
    FwdExm  = 2'd1,
    FwdMwb  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                      valid;
    logic [RvRegAddrWidth-1:0] rs1;
    logic [RvRegAddrWidth-1:0] rs2;
    logic [RvWordWidth-1:0]    op1;
    logic [RvWordWidth-1:0]    op2;
    logic [RvWordWidth-1:0]    imm;
    logic [RvWordWidth-1:0]    pc;
    logic                      use_imm;
    logic                      use_pc;
    logic [RvAluCtlWidth-1:0]  ctl;
    logic [RvRegAddrWidth-1:0] rd_addr;
    logic                      rd_we;
  } issue_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Priority forward match for one source tag: EX/MEM beats MEM/WB, x0 never hits.
// value carries the winning source result and is only meaningful when hit is set.
module fwd_select
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WIDTH      = RvWordWidth,
  parameter int unsigned ADDR_WIDTH = RvRegAddrWidth
) (
  input  logic [ADDR_WIDTH-1:0] tag,
  input  logic                  exm_valid,
  input  logic                  exm_rd_we,
  input  logic [ADDR_WIDTH-1:0] exm_rd_addr,
  input  logic [WIDTH-1:0]      exm_result,
  input  logic                  mwb_valid,
  input  logic                  mwb_rd_we,
  input  logic [ADDR_WIDTH-1:0] mwb_rd_addr,
  input  logic [WIDTH-1:0]      mwb_result,
  output logic [WIDTH-1:0]      value,
  output logic                  hit
);

  fwd_sel_e sel;

  always_comb begin
    sel = FwdNone;
    if (tag != '0) begin
      if (exm_valid && exm_rd_we && (exm_rd_addr == tag)) begin
        sel = FwdExm;
      end else if (mwb_valid && mwb_rd_we && (mwb_rd_addr == tag)) begin
        sel = FwdMwb;
      end
    end
  end

  always_comb begin
    value = '0;
    unique case (sel)
      FwdExm:  value = exm_result;
      FwdMwb:  value = mwb_result;
      default: value = '0;
    endcase
  end

  assign hit = (sel != FwdNone);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: main + skid entry buffer with a registered
// in_ready, operand forwarding at capture and continuous snooping while buffered.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = RvWordWidth,
  parameter int unsigned REG_ADDR_WIDTH = RvRegAddrWidth,
  parameter int unsigned CTL_WIDTH      = RvAluCtlWidth
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,

  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [WORD_WIDTH-1:0]     in_rs1_data,
  input  logic [WORD_WIDTH-1:0]     in_rs2_data,
  input  logic [WORD_WIDTH-1:0]     in_imm,
  input  logic [WORD_WIDTH-1:0]     in_pc,
  input  logic                      in_use_imm,
  input  logic                      in_use_pc,
  input  logic [CTL_WIDTH-1:0]      in_ctl,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_rd_we,

  input  logic                      exm_valid,
  input  logic                      exm_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd_addr,
  input  logic [WORD_WIDTH-1:0]     exm_result,
  input  logic                      mwb_valid,
  input  logic                      mwb_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] mwb_rd_addr,
  input  logic [WORD_WIDTH-1:0]     mwb_result,

  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_WIDTH-1:0]     out_a,
  output logic [WORD_WIDTH-1:0]     out_b,
  output logic [CTL_WIDTH-1:0]      out_ctl,
  output logic [WORD_WIDTH-1:0]     out_store_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_rd_we
);

  // Forward lookups: 0/1 capture rs1/rs2, 2/3 main op1/op2, 4/5 skid op1/op2.
  localparam int unsigned NumFwd = 6;

  issue_entry_t main_q, main_d, skid_q, skid_d;
  issue_entry_t main_s, skid_s, cap;
  logic         in_ready_q, in_ready_d;
  logic         accept, xfer;

  logic [REG_ADDR_WIDTH-1:0] fwd_tag [NumFwd];
  logic [WORD_WIDTH-1:0]     fwd_val [NumFwd];
  logic                      fwd_hit [NumFwd];

  assign fwd_tag[0] = in_rs1_addr;
  assign fwd_tag[1] = in_rs2_addr;
  assign fwd_tag[2] = main_q.rs1;
  assign fwd_tag[3] = main_q.rs2;
  assign fwd_tag[4] = skid_q.rs1;
  assign fwd_tag[5] = skid_q.rs2;

  for (genvar i = 0; i < NumFwd; i++) begin : gen_fwd
    fwd_select #(
      .WIDTH      (WORD_WIDTH),
      .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd (
      .tag         (fwd_tag[i]),
      .exm_valid   (exm_valid),
      .exm_rd_we   (exm_rd_we),
      .exm_rd_addr (exm_rd_addr),
      .exm_result  (exm_result),
      .mwb_valid   (mwb_valid),
      .mwb_rd_we   (mwb_rd_we),
      .mwb_rd_addr (mwb_rd_addr),
      .mwb_result  (mwb_result),
      .value       (fwd_val[i]),
      .hit         (fwd_hit[i])
    );
  end

  assign accept = in_valid & in_ready;
  assign xfer   = main_q.valid & out_ready;

  always_comb begin
    cap         = '0;
    cap.valid   = 1'b1;
    cap.rs1     = in_rs1_addr;
    cap.rs2     = in_rs2_addr;
    cap.op1     = fwd_hit[0] ? fwd_val[0] : in_rs1_data;
    cap.op2     = fwd_hit[1] ? fwd_val[1] : in_rs2_data;
    cap.imm     = in_imm;
    cap.pc      = in_pc;
    cap.use_imm = in_use_imm;
    cap.use_pc  = in_use_pc;
    cap.ctl     = in_ctl;
    cap.rd_addr = in_rd_addr;
    cap.rd_we   = in_rd_we;
  end

  // Snooped views keep buffered operands current with in-flight results.
  always_comb begin
    main_s = main_q;
    skid_s = skid_q;
    if (main_q.valid && fwd_hit[2]) main_s.op1 = fwd_val[2];
    if (main_q.valid && fwd_hit[3]) main_s.op2 = fwd_val[3];
    if (skid_q.valid && fwd_hit[4]) skid_s.op1 = fwd_val[4];
    if (skid_q.valid && fwd_hit[5]) skid_s.op2 = fwd_val[5];
  end

  always_comb begin
    main_d = main_s;
    skid_d = skid_s;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (!main_q.valid || xfer) begin
      if (skid_q.valid) begin
        main_d = skid_s;
        if (accept) begin
          skid_d = cap;
        end else begin
          skid_d.valid = 1'b0;
        end
      end else if (accept) begin
        main_d = cap;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = cap;
    end
    in_ready_d = ~skid_d.valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Held low during reset so decode never hands over an instruction that would be dropped.
  assign in_ready       = in_ready_q & ~rst;

  assign out_valid      = main_q.valid;
  assign out_a          = main_q.use_pc ? main_q.pc : main_q.op1;
  assign out_b          = main_q.use_imm ? main_q.imm : main_q.op2;
  assign out_ctl        = main_q.ctl;
  assign out_store_data = main_q.op2;
  assign out_rd_addr    = main_q.rd_addr;
  assign out_rd_we      = main_q.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized scoreboard bench for alu_issue_stage: a queue-based model of the
// buffered instructions is snooped each cycle and checked at every output transfer.
module tb_alu_issue_stage;

  logic        clk, rst, flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_use_pc, in_rd_we;
  logic [3:0]  in_ctl;
  logic        exm_valid, exm_rd_we, mwb_valid, mwb_rd_we;
  logic [4:0]  exm_rd_addr, mwb_rd_addr;
  logic [31:0] exm_result, mwb_result;
  logic        out_valid, out_ready, out_rd_we;
  logic [31:0] out_a, out_b, out_store_data;
  logic [3:0]  out_ctl;
  logic [4:0]  out_rd_addr;

  alu_issue_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_pc          (in_pc),
    .in_use_imm     (in_use_imm),
    .in_use_pc      (in_use_pc),
    .in_ctl         (in_ctl),
    .in_rd_addr     (in_rd_addr),
    .in_rd_we       (in_rd_we),
    .exm_valid      (exm_valid),
    .exm_rd_we      (exm_rd_we),
    .exm_rd_addr    (exm_rd_addr),
    .exm_result     (exm_result),
    .mwb_valid      (mwb_valid),
    .mwb_rd_we      (mwb_rd_we),
    .mwb_rd_addr    (mwb_rd_addr),
    .mwb_result     (mwb_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_a          (out_a),
    .out_b          (out_b),
    .out_ctl        (out_ctl),
    .out_store_data (out_store_data),
    .out_rd_addr    (out_rd_addr),
    .out_rd_we      (out_rd_we)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] op1, op2, imm, pc;
    logic        use_imm, use_pc, we;
    logic [3:0]  ctl;
  } item_t;

  item_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    armed = 0;
  bit    post_rst = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a source register should carry given the results in flight this cycle.
  function automatic logic [31:0] fwd(input logic [4:0] tag, input logic [31:0] v);
    if (tag == 5'd0) return v;
    if (exm_valid && exm_rd_we && exm_rd_addr == tag) return exm_result;
    if (mwb_valid && mwb_rd_we && mwb_rd_addr == tag) return mwb_result;
    return v;
  endfunction

  // Monitor / scoreboard: reads everything 1ns after the driver's negedge update.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        armed    = 1;
        post_rst = 1;
        chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
        q.delete();
      end else if (armed) begin
        if (post_rst) begin
          chk("rst_out_a", out_a, 32'd0);
          chk("rst_out_b", out_b, 32'd0);
          chk("rst_store", out_store_data, 32'd0);
          chk("rst_rd", {24'd0, out_ctl, out_rd_addr[3:0]} | {31'd0, out_rd_we}, 32'd0);
          post_rst = 0;
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("out_a", out_a, e.use_pc ? e.pc : e.op1);
          chk("out_b", out_b, e.use_imm ? e.imm : e.op2);
          chk("store_data", out_store_data, e.op2);
          chk("ctl_rd_we", {22'd0, out_ctl, out_rd_addr, out_rd_we}, {22'd0, e.ctl, e.rd, e.we});
        end
        if (flush) begin
          q.delete();
        end else begin
          for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            e.op1 = fwd(e.rs1, e.op1);
            e.op2 = fwd(e.rs2, e.op2);
            q[i] = e;
          end
          if (in_valid && in_ready) begin
            e.rs1 = in_rs1_addr;  e.rs2 = in_rs2_addr;  e.rd = in_rd_addr;
            e.op1 = fwd(in_rs1_addr, in_rs1_data);
            e.op2 = fwd(in_rs2_addr, in_rs2_data);
            e.imm = in_imm;  e.pc = in_pc;  e.use_imm = in_use_imm;  e.use_pc = in_use_pc;
            e.we  = in_rd_we;  e.ctl = in_ctl;
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic quiet();
    flush = 0;  in_valid = 0;  in_use_imm = 0;  in_use_pc = 0;
    in_imm = 0;  in_pc = 0;  in_ctl = 0;  in_rd_addr = 0;  in_rd_we = 0;
    in_rs1_addr = 0;  in_rs2_addr = 0;  in_rs1_data = 0;  in_rs2_data = 0;
    exm_valid = 0;  exm_rd_we = 0;  exm_rd_addr = 0;  exm_result = 0;
    mwb_valid = 0;  mwb_rd_we = 0;  mwb_rd_addr = 0;  mwb_result = 0;
  endtask

  task automatic instr(input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd);
    in_valid = 1;  in_rs1_addr = r1;  in_rs1_data = d1;  in_rs2_addr = r2;  in_rs2_data = d2;
    in_rd_addr = rd;  in_rd_we = 1;  in_ctl = 4'h0;
  endtask

  task automatic exm(input logic [4:0] rd, input logic [31:0] v);
    exm_valid = 1;  exm_rd_we = 1;  exm_rd_addr = rd;  exm_result = v;
  endtask

  task automatic mwb(input logic [4:0] rd, input logic [31:0] v);
    mwb_valid = 1;  mwb_rd_we = 1;  mwb_rd_addr = rd;  mwb_result = v;
  endtask

  task automatic randomize_inputs();
    rst         = ($urandom_range(0, 199) == 0);
    flush       = ($urandom_range(0, 29) == 0);
    in_valid    = ($urandom_range(0, 9) < 7);
    out_ready   = ($urandom_range(0, 9) < 6);
    in_rs1_addr = 5'($urandom_range(0, 7));
    in_rs2_addr = 5'($urandom_range(0, 7));
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    in_imm      = $urandom;
    in_pc       = $urandom;
    in_use_imm  = 1'($urandom);
    in_use_pc   = 1'($urandom);
    in_ctl      = 4'($urandom);
    in_rd_addr  = 5'($urandom);
    in_rd_we    = 1'($urandom);
    exm_valid   = 1'($urandom);
    exm_rd_we   = ($urandom_range(0, 9) < 8);
    exm_rd_addr = 5'($urandom_range(0, 7));
    exm_result  = $urandom;
    mwb_valid   = 1'($urandom);
    mwb_rd_we   = ($urandom_range(0, 9) < 8);
    mwb_rd_addr = 5'($urandom_range(0, 7));
    mwb_result  = $urandom;
  endtask

  initial begin
    rst = 1;  out_ready = 1;  quiet();
    repeat (2) @(negedge clk);
    @(negedge clk);  rst = 0;

    // Back-to-back ADDs, no hazards.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);  quiet();  out_ready = 1;  instr(5'd1, 32'h5, 5'd2, 32'h7, 5'(10 + i));
    end
    // Forward priority on x3, then MEM/WB alone.
    @(negedge clk);  quiet();  instr(5'd3, 32'h1111, 5'd0, 32'h0, 5'd8);
    exm(5'd3, 32'hAAAA);  mwb(5'd3, 32'hBBBB);
    @(negedge clk);  quiet();  instr(5'd3, 32'h1111, 5'd0, 32'h0, 5'd8);  mwb(5'd3, 32'hBBBB);
    @(negedge clk);  quiet();
    // Stall: fill main and skid, snoop x4 into main while stalled, then drain.
    @(negedge clk);  quiet();  out_ready = 0;  instr(5'd1, 32'h1, 5'd4, 32'h9, 5'd11);
    @(negedge clk);  quiet();  instr(5'd2, 32'h2, 5'd5, 32'h3, 5'd12);
    @(negedge clk);  quiet();  instr(5'd6, 32'h6, 5'd6, 32'h6, 5'd13);  mwb(5'd4, 32'h42);
    repeat (3) begin @(negedge clk);  quiet();  out_ready = 1; end
    // x0 never forwards.
    @(negedge clk);  quiet();  instr(5'd0, 32'h0, 5'd0, 32'h0, 5'd1);  exm(5'd0, 32'hDEAD);
    // PC/immediate select with a forwarded store operand.
    @(negedge clk);  quiet();  instr(5'd1, 32'h1, 5'd7, 32'h77, 5'd2);  exm(5'd7, 32'h1234);
    in_use_pc = 1;  in_pc = 32'h100;  in_use_imm = 1;  in_imm = 32'hFFFF_FFFC;
    // Flush with both entries full and a new instruction offered.
    @(negedge clk);  quiet();  out_ready = 0;  instr(5'd1, 32'h10, 5'd2, 32'h20, 5'd3);
    @(negedge clk);  quiet();  instr(5'd1, 32'h11, 5'd2, 32'h21, 5'd4);
    @(negedge clk);  quiet();  instr(5'd1, 32'h12, 5'd2, 32'h22, 5'd5);  flush = 1;
    @(negedge clk);  quiet();
    // Reset in the middle of a stall.
    @(negedge clk);  quiet();  instr(5'd1, 32'h30, 5'd2, 32'h31, 5'd6);
    @(negedge clk);  quiet();  instr(5'd1, 32'h32, 5'd2, 32'h33, 5'd7);
    @(negedge clk);  quiet();  rst = 1;
    @(negedge clk);  quiet();  rst = 0;  out_ready = 1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);  randomize_inputs();
    end

    @(negedge clk);  quiet();  rst = 0;  out_ready = 1;
    repeat (6) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX boundary stage that directly feeds the ALU. It captures decoded instructions from decode with a valid/ready handshake and resolves operand forwarding from the EX/MEM and MEM/WB stages. It keeps forwarded values fresh while an instruction is stalled, then presents ALU operands a/b/ctl plus writeback and store metadata downstream. A 2-entry skid buffer (main + skid) keeps in_ready a registered signal.

Parameters:
WORD_WIDTH, 32, datapath width (matches `WORD_WIDTH)
REG_ADDR_WIDTH, 5, register index width
CTL_WIDTH, 4, ALU control width (matches `ALU_CTL_WIDTH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill all buffered instructions (branch/jump redirect)
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept; registered
in_rs1_addr / in_rs2_addr  in  REG_ADDR_WIDTH  source register tags
in_rs1_data / in_rs2_data  in  WORD_WIDTH  register-file read values
in_imm  in  WORD_WIDTH  sign-extended immediate
in_pc  in  WORD_WIDTH  instruction PC
in_use_imm  in  1  out_b takes imm instead of rs2
in_use_pc  in  1  out_a takes pc instead of rs1
in_ctl  in  CTL_WIDTH  ALU operation
in_rd_addr  in  REG_ADDR_WIDTH  destination register
in_rd_we  in  1  destination write enable
exm_valid, exm_rd_we  in  1 each  EX/MEM forward source qualifiers
exm_rd_addr  in  REG_ADDR_WIDTH  EX/MEM destination
exm_result  in  WORD_WIDTH  EX/MEM result
mwb_valid, mwb_rd_we  in  1 each  MEM/WB forward source qualifiers
mwb_rd_addr  in  REG_ADDR_WIDTH  MEM/WB destination
mwb_result  in  WORD_WIDTH  MEM/WB result
out_valid  out  1  main entry holds an instruction
out_ready  in  1  ALU/EX stage accepts
out_a, out_b  out  WORD_WIDTH  ALU operands
out_ctl  out  CTL_WIDTH  ALU control
out_store_data  out  WORD_WIDTH  forwarded rs2 value, used for stores
out_rd_addr  out  REG_ADDR_WIDTH  destination register
out_rd_we  out  1  destination write enable

Behaviour:
- Entry contents: rs1/rs2 tags, op1/op2 values, imm, pc, use_imm, use_pc, ctl, rd_addr, rd_we, valid.
- Outputs are driven from the main entry only.
  - out_a = use_pc ? pc : op1
  - out_b = use_imm ? imm : op2
  - out_store_data = op2
- Forward match for source tag t: t != 0 and src_valid and src_rd_we and src_rd_addr == t. EX/MEM beats MEM/WB; otherwise the value is unchanged.
- Forwarding applies to in_rsN_data at capture, in the same cycle as capture.
- Snoop: every cycle, each occupied entry's op1/op2 is overwritten by a matching forward source. Sources are sampled in the same cycle as capture, so an entry is never stale.
- A tag of 0 never matches; op values for x0 stay as captured.
- Handshake: accept when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Main/skid transfer rules:
  - Main empty or transferring: the incoming instruction goes to main if skid is empty; otherwise skid moves to main and the incoming instruction goes to skid.
  - Main full and not transferring: the incoming instruction goes to skid.
- in_ready is registered and equals ~skid_valid.
- Throughput is 1 instruction/cycle when out_ready is held high; latency is 1 cycle from accept to out_valid.
- out_* stays stable while out_valid & ~out_ready, except op values updated by snoop.
- Flush: next cycle both entries are invalid and in_ready=1. A simultaneous input is dropped. Flush dominates accept and transfer; a same-cycle output transfer still completes downstream.
- Reset: next cycle out_valid=0, in_ready=1, all data registers 0. in_ready=0 while rst is high. Reset mid-stall discards everything.
- No arithmetic is performed; all widths pass through unchanged.

Decomposition:
- Forward-select encoding (NONE/EXM/MWB) and the instruction-entry struct go in a shared rv32i package/defs file alongside `WORD_WIDTH and `ALU_CTL_WIDTH.
- One sub-module, fwd_select: combinational priority match returning the chosen value and a hit flag. It is instantiated 6 times: capture rs1/rs2 plus 2 entries × 2 operands.

Test Plan:
- Back-to-back ADD with no hazards, out_ready=1: in rs1=0x5, rs2=0x7, ctl=ALU_ADD -> next cycle out_a=5, out_b=7, out_valid=1; sustained 1/cycle, in_ready stays 1.
- EX/MEM and MEM/WB both write x3 (0xAAAA and 0xBBBB), in rs1=x3, regfile value 0x1111 -> out_a=0xAAAA. With only MEM/WB matching -> 0xBBBB.
- Stall, out_ready=0 for 3 cycles:
  - second accept fills skid, then in_ready=0;
  - mwb writes x4=0x42 while main rs2=x4 -> out_b/out_store_data become 0x42;
  - release -> both drain in order.
- x0 safety: exm writes rd=0 value 0xDEAD, in rs1=x0 data 0 -> out_a=0.
- Immediate/PC select: use_pc=1, pc=0x100, use_imm=1, imm=0xFFFFFFFC -> out_a=0x100, out_b=0xFFFFFFFC, out_store_data=forwarded rs2.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the new instruction is not captured. rst pulse mid-stall gives the same result with data regs=0.
